seq_signed_divider: RTL and testbench

//  Iterative restoring divider for signed two's-complement operands; the subtract-and-shift inverse of the adder datapath.

---
 rtl/seq_signed_divider_pkg.sv | 20 ++
 rtl/seq_signed_divider_step.sv | 29 ++
 rtl/seq_signed_divider.sv | 154 +++++++++++++++
 tb/tb_seq_signed_divider.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_signed_divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
package seq_signed_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Ceiling log2, used to size the bit counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_signed_divider_step.sv
// One restoring-division step: shift {rem,quo} left and try to subtract the divisor.
module seq_signed_divider_step #(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic [BIT_WIDTH-1:0] rem_in,
  input  logic [BIT_WIDTH-1:0] quo_in,
  input  logic [BIT_WIDTH-1:0] divisor,
  output logic [BIT_WIDTH-1:0] rem_out,
  output logic [BIT_WIDTH-1:0] quo_out
);

  localparam int unsigned EXT_W = BIT_WIDTH + 1;

  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] trial;

  // Trial subtract is one bit wider so its MSB is the borrow/sign.
  always_comb begin
    shifted = {rem_in, quo_in[BIT_WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[EXT_W-1]) begin
      rem_out = trial[BIT_WIDTH-1:0];
    end else begin
      rem_out = shifted[BIT_WIDTH-1:0];
    end
    quo_out = {quo_in[BIT_WIDTH-2:0], ~trial[EXT_W-1]};
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed restoring divider, one quotient bit per cycle, valid/ready on both sides.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] dividend,
  input  logic [BIT_WIDTH-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] quotient,
  output logic [BIT_WIDTH-1:0] remainder,
  output logic                 overflow,
  output logic                 div_by_zero,
  output logic                 negative
);

  localparam int unsigned CNT_W = clog2(BIT_WIDTH);
  localparam logic [BIT_WIDTH-1:0] MIN_MAG = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] ONE     = BIT_WIDTH'(1);

  div_state_e state, state_n;

  logic [BIT_WIDTH-1:0] rem, rem_n;
  logic [BIT_WIDTH-1:0] quo, quo_n;
  logic [BIT_WIDTH-1:0] dvs_mag, dvs_mag_n;
  logic                 sign_a, sign_a_n;
  logic                 sign_b, sign_b_n;
  logic                 zero_div, zero_div_n;
  logic [CNT_W-1:0]     cnt, cnt_n;

  logic [BIT_WIDTH-1:0] quotient_n, remainder_n;
  logic                 overflow_n, div_by_zero_n, negative_n;
  logic                 in_ready_n, out_valid_n;

  logic [BIT_WIDTH-1:0] step_rem, step_quo;

  seq_signed_divider_step #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvs_mag),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state, datapath and output computation.
  always_comb begin
    state_n       = state;
    rem_n         = rem;
    quo_n         = quo;
    dvs_mag_n     = dvs_mag;
    sign_a_n      = sign_a;
    sign_b_n      = sign_b;
    zero_div_n    = zero_div;
    cnt_n         = cnt;
    quotient_n    = quotient;
    remainder_n   = remainder;
    overflow_n    = overflow;
    div_by_zero_n = div_by_zero;

    unique case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          sign_a_n   = dividend[BIT_WIDTH-1];
          sign_b_n   = divisor[BIT_WIDTH-1];
          quo_n      = dividend[BIT_WIDTH-1] ? -dividend : dividend;
          dvs_mag_n  = divisor[BIT_WIDTH-1] ? -divisor : divisor;
          rem_n      = '0;
          zero_div_n = (divisor == '0);
          cnt_n      = CNT_W'(BIT_WIDTH - 1);
          // A zero divisor skips the iteration and only needs the fix-up cycle.
          state_n    = (divisor == '0) ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        rem_n = step_rem;
        quo_n = step_quo;
        if (cnt == '0) state_n = ST_FIX;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      ST_FIX: begin
        if (zero_div) begin
          // quo still holds |dividend|; restore the original dividend.
          quotient_n    = '1;
          remainder_n   = sign_a ? -quo : quo;
          overflow_n    = 1'b0;
          div_by_zero_n = 1'b1;
        end else begin
          quotient_n    = (sign_a ^ sign_b) ? -quo : quo;
          remainder_n   = sign_a ? -rem : rem;
          overflow_n    = sign_a && sign_b && (quo == MIN_MAG) && (dvs_mag == ONE);
          div_by_zero_n = 1'b0;
        end
        state_n = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    negative_n  = quotient_n[BIT_WIDTH-1];
    in_ready_n  = (state_n == ST_IDLE);
    out_valid_n = (state_n == ST_DONE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      quo         <= '0;
      dvs_mag     <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      zero_div    <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      negative    <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      rem         <= rem_n;
      quo         <= quo_n;
      dvs_mag     <= dvs_mag_n;
      sign_a      <= sign_a_n;
      sign_b      <= sign_b_n;
      zero_div    <= zero_div_n;
      cnt         <= cnt_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      overflow    <= overflow_n;
      div_by_zero <= div_by_zero_n;
      negative    <= negative_n;
      in_ready    <= in_ready_n;
      out_valid   <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider at BIT_WIDTH=8.
module tb_seq_signed_divider;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         overflow;
  logic         div_by_zero;
  logic         negative;

  int checks = 0;
  int errors = 0;
  int lat;

  seq_signed_divider #(.BIT_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .negative    (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, present operands for exactly one accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  // Count edges from the accepting edge until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic ovf, input logic dz, input logic neg);
    check({tag, "_q"},   32'(quotient),    32'(q));
    check({tag, "_r"},   32'(remainder),   32'(r));
    check({tag, "_ovf"}, 32'(overflow),    32'(ovf));
    check({tag, "_dz"},  32'(div_by_zero), 32'(dz));
    check({tag, "_neg"}, 32'(negative),    32'(neg));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_consume", 32'(out_valid), 32'd0);
    check("in_ready_after_consume", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic ovf, input logic dz, input logic neg, input int exp_lat);
    int n;
    start_op(a, b);
    wait_valid(n);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_res(tag, q, r, ovf, dz, neg);
    consume();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check_res("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 100/7 = 14 r 2
    run_op("p100_p7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 9);
    // -100/7 = -14 r -2
    run_op("m100_p7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 1'b1, 9);
    // 100/-7 = -14 r 2
    run_op("p100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 1'b1, 9);
    // 7/0 -> all ones, remainder = dividend
    run_op("p7_z", 8'd7, 8'd0, 8'hFF, 8'h07, 1'b0, 1'b1, 1'b1, 1);
    // -5/0 -> all ones, remainder = -5
    run_op("m5_z", 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b0, 1'b1, 1'b1, 1);
    // -128/-1 wraps to -128 with overflow
    run_op("min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 9);
    // -128/1 = -128, no overflow
    run_op("min_p1", 8'h80, 8'd1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 9);
    // -128/7 = -18 r -2
    run_op("min_p7", 8'h80, 8'd7, 8'hEE, 8'hFE, 1'b0, 1'b0, 1'b1, 9);
    // 127/-128 = 0 r 127
    run_op("max_min", 8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, 9);
    // 3/7 = 0 r 3 ; 5/5 = 1 r 0
    run_op("p3_p7", 8'd3, 8'd7, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 9);
    run_op("p5_p5", 8'd5, 8'd5, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 9);

    // out_ready held high throughout: ignored during CALC, one-cycle out_valid pulse.
    out_ready = 1'b1;
    start_op(8'h9C, 8'hF9);
    wait_valid(lat);
    check("held_ready_lat", 32'(lat), 32'd9);
    check_res("held_ready", 8'h0E, 8'hFE, 1'b0, 1'b0, 1'b0);
    tick();
    check("held_ready_pulse", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Backpressure: results held, new request not accepted until released.
    start_op(8'd100, 8'd7);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd9);
    dividend = 8'd50;
    divisor  = 8'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'h0E);
      check("bp_remainder", 32'(remainder), 32'h02);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_accept_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check("bp_next_lat", 32'(lat), 32'd9);
    check_res("bp_next", 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0);
    consume();

    // Reset during CALC cycle 4 discards the operation.
    start_op(8'd100, 8'd7);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check_res("midrst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("midrst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    run_op("after_rst", 8'd50, 8'd5, 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
